canvas_write_arbiter: RTL and testbench
=======================================

CANVAS_WRITE_ARBITER -- requirements
Module: canvas_write_arbiter

Interface
REQ-001 Parameter CANVAS_X0, default 9'd89, left column of the drawing canvas.
REQ-002 Parameter CANVAS_Y0, default 9'd33, top row of the drawing canvas.
REQ-003 Parameter CANVAS_W, default 9'd140, canvas width in pixels.
REQ-004 Parameter CANVAS_H, default 9'd196, canvas height in pixels.
REQ-005 Parameter BG_COLOUR, default 15'h7FFF, canvas clear colour.
REQ-006 clock  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 clr_req  in  1  request full-canvas clear; level-sampled in IDLE.
REQ-009 brush_req / brush_x[8:0] / brush_y[8:0] / brush_colour[14:0]  in  brush pixel write request and payload.
REQ-010 ovl_req / ovl_x[8:0] / ovl_y[8:0] / ovl_colour[14:0]  in  overlay (prediction glyph) pixel write request and payload.
REQ-011 brush_ack, ovl_ack  out  1 each  grant strobes.
REQ-012 x[8:0], y[8:0], colour[14:0], plot  out  registered pixel write port to the VGA adapter.
REQ-013 clearing  out  1  high while the clear sweep runs; clr_done  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states: IDLE, CLEAR; no other states.
REQ-015 IDLE -> CLEAR when clr_req=1; sweep counters cx, cy load 0.
REQ-016 In CLEAR, each cycle issues one write (CANVAS_X0+cx, CANVAS_Y0+cy, BG_COLOUR); cx increments, wraps to 0 at CANVAS_W-1 and cy increments; row-major order.
REQ-017 CLEAR -> IDLE after write (CANVAS_X0+CANVAS_W-1, CANVAS_Y0+CANVAS_H-1); exactly CANVAS_W*CANVAS_H writes (27440 at defaults).
REQ-018 clr_done SHALL be high in the same cycle plot is high for the final sweep pixel, and only then.
REQ-019 clr_req asserted during CLEAR is ignored; no restart, no queuing.
REQ-020 Priority: CLEAR sweep > aged overlay > brush > overlay.
REQ-021 In CLEAR, brush_ack=ovl_ack=0; pending requests wait.
REQ-022 brush_ack / ovl_ack are combinational and high in the grant cycle only; at most one ack per cycle.
REQ-023 Requester holds req and payload until ack; a req still high in the cycle after ack is a new transaction.
REQ-024 Granted payload appears on x, y, colour with plot=1 on the next cycle (latency 1); plot=0 in any cycle following no grant and no sweep write.
REQ-025 Brush clipping: brush write outside [CANVAS_X0, CANVAS_X0+CANVAS_W-1] x [CANVAS_Y0, CANVAS_Y0+CANVAS_H-1] is acked but produces plot=0.
REQ-026 Overlay clipping: ovl_x>=320 or ovl_y>=240 is acked but produces plot=0; otherwise any screen location is legal.
REQ-027 Aging: 3-bit ovl_wait increments (saturating at 7) each IDLE cycle with ovl_req=1 and no ovl grant; cleared on ovl grant; frozen in CLEAR.
REQ-028 ovl_wait=7 makes overlay win over a simultaneous brush request.
REQ-029 clr_req and brush/ovl requests in the same IDLE cycle: clear wins; no ack that cycle; first sweep write plots next cycle.
REQ-030 Overlay-only or brush-only request in IDLE is granted the same cycle.

Reset
REQ-031 reset=1 forces state IDLE, cx=cy=0, ovl_wait=0, x=y=0, colour=0, plot=0, clr_done=0, clearing=0, acks=0, asynchronously.
REQ-032 Reset mid-sweep aborts the clear without a clr_done pulse; after release the block is in IDLE.

Verification
REQ-033 Clear: pulse clr_req in IDLE -> clearing=1 next cycle; first plot (89,33,7FFF); last plot (228,228) with clr_done=1 after exactly 27440 plots; clearing=0 after.
REQ-034 Brush single write: brush_req (100,50,001F) in IDLE -> brush_ack same cycle; next cycle plot=1, x=100, y=50, colour=001F.
REQ-035 Clip: brush (10,10) -> ack, plot=0; overlay (320,5) -> ack, plot=0; overlay (300,5) -> plot=1.
REQ-036 Aging: brush_req and ovl_req held high continuously -> 7 brush grants, then 1 ovl grant, pattern repeats.
REQ-037 Contention: brush_req held during clr_req -> no brush_ack for 27440 sweep cycles; brush_ack in the first IDLE cycle after clr_done.
REQ-038 Reset mid-sweep at plot 1000 -> plot=0, clearing=0 immediately; clr_done never pulses; subsequent clr_req restarts from (89,33).

Source files
------------

// File: rtl/canvas_write_arbiter.sv
// rtl/canvas_write_arbiter.sv - pixel write arbiter for canvas clear sweep, brush and overlay
//
// Purpose: merges three pixel sources onto one registered VGA write port.
//    A full-canvas clear sweep has absolute priority; otherwise an overlay
//    request that has waited 7 cycles beats the brush, the brush beats a
//    fresh overlay request. Clipped writes are acknowledged but not plotted.
// Ports:
//    clock, reset                   single clock, async active-high reset
//    clr_req                        start a canvas clear (sampled in IDLE only)
//    brush_req/x/y/colour, brush_ack   brush write request, payload, grant
//    ovl_req/x/y/colour, ovl_ack       overlay write request, payload, grant
//    x, y, colour, plot             registered pixel write (one cycle after grant)
//    clearing                       clear sweep in progress
//    clr_done                       pulses with the final sweep pixel

module canvas_write_arbiter #(
   parameter logic [8:0]  CANVAS_X0 = 9'd89,
   parameter logic [8:0]  CANVAS_Y0 = 9'd33,
   parameter logic [8:0]  CANVAS_W  = 9'd140,
   parameter logic [8:0]  CANVAS_H  = 9'd196,
   parameter logic [14:0] BG_COLOUR = 15'h7FFF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clr_req,
   input  logic        brush_req,
   input  logic [8:0]  brush_x,
   input  logic [8:0]  brush_y,
   input  logic [14:0] brush_colour,
   input  logic        ovl_req,
   input  logic [8:0]  ovl_x,
   input  logic [8:0]  ovl_y,
   input  logic [14:0] ovl_colour,
   output logic        brush_ack,
   output logic        ovl_ack,
   output logic [8:0]  x,
   output logic [8:0]  y,
   output logic [14:0] colour,
   output logic        plot,
   output logic        clearing,
   output logic        clr_done
);

   typedef enum logic {IDLE, CLEAR} state_t;

   // Inclusive canvas bounds, computed one bit wider so wide parameter
   // choices cannot wrap.
   localparam logic [9:0] X_HI = {1'b0, CANVAS_X0} + {1'b0, CANVAS_W} - 10'd1;
   localparam logic [9:0] Y_HI = {1'b0, CANVAS_Y0} + {1'b0, CANVAS_H} - 10'd1;

   state_t      state, state_nxt;
   logic [8:0]  cx, cy;
   logic [2:0]  ovl_wait;
   logic        sweep_last;
   logic        brush_in;
   logic        ovl_in;

   assign sweep_last = (cx == CANVAS_W - 9'd1) && (cy == CANVAS_H - 9'd1);

   assign brush_in = (brush_x >= CANVAS_X0) && ({1'b0, brush_x} <= X_HI) &&
                     (brush_y >= CANVAS_Y0) && ({1'b0, brush_y} <= Y_HI);

   assign ovl_in = (ovl_x < 9'd320) && (ovl_y < 9'd240);

   always_comb begin
      state_nxt = state;
      brush_ack = 1'b0;
      ovl_ack   = 1'b0;
      clearing  = (state == CLEAR);
      case (state)
         IDLE: begin
            // Acks are combinational, so gate them while reset is held.
            if (!reset) begin
               if (clr_req) begin
                  state_nxt = CLEAR;
               end else if (ovl_req && (ovl_wait == 3'd7 || !brush_req)) begin
                  ovl_ack = 1'b1;
               end else if (brush_req) begin
                  brush_ack = 1'b1;
               end
            end
         end
         CLEAR: begin
            if (sweep_last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cx       <= '0;
         cy       <= '0;
         ovl_wait <= '0;
         x        <= '0;
         y        <= '0;
         colour   <= '0;
         plot     <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         plot     <= 1'b0;
         clr_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clr_req) begin
                  cx <= '0;
                  cy <= '0;
               end
               if (ovl_ack) begin
                  ovl_wait <= '0;
               end else if (ovl_req && ovl_wait != 3'd7) begin
                  ovl_wait <= ovl_wait + 3'd1;
               end
               if (brush_ack) begin
                  x      <= brush_x;
                  y      <= brush_y;
                  colour <= brush_colour;
                  plot   <= brush_in;
               end
               if (ovl_ack) begin
                  x      <= ovl_x;
                  y      <= ovl_y;
                  colour <= ovl_colour;
                  plot   <= ovl_in;
               end
            end
            CLEAR: begin
               x        <= CANVAS_X0 + cx;
               y        <= CANVAS_Y0 + cy;
               colour   <= BG_COLOUR;
               plot     <= 1'b1;
               clr_done <= sweep_last;
               if (sweep_last) begin
                  cx <= '0;
                  cy <= '0;
               end else if (cx == CANVAS_W - 9'd1) begin
                  cx <= '0;
                  cy <= cy + 9'd1;
               end else begin
                  cx <= cx + 9'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// tb/tb_canvas_write_arbiter.sv - scoreboard bench for canvas_write_arbiter

module tb_canvas_write_arbiter;

   typedef struct packed {
      logic [8:0]  px;
      logic [8:0]  py;
      logic [14:0] pc;
      logic        done;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        clr_req;
   logic        brush_req;
   logic [8:0]  brush_x;
   logic [8:0]  brush_y;
   logic [14:0] brush_colour;
   logic        ovl_req;
   logic [8:0]  ovl_x;
   logic [8:0]  ovl_y;
   logic [14:0] ovl_colour;
   logic        brush_ack;
   logic        ovl_ack;
   logic [8:0]  x;
   logic [8:0]  y;
   logic [14:0] colour;
   logic        plot;
   logic        clearing;
   logic        clr_done;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   canvas_write_arbiter dut (
      .clock(clock), .reset(reset), .clr_req(clr_req),
      .brush_req(brush_req), .brush_x(brush_x), .brush_y(brush_y),
      .brush_colour(brush_colour),
      .ovl_req(ovl_req), .ovl_x(ovl_x), .ovl_y(ovl_y), .ovl_colour(ovl_colour),
      .brush_ack(brush_ack), .ovl_ack(ovl_ack),
      .x(x), .y(y), .colour(colour), .plot(plot),
      .clearing(clearing), .clr_done(clr_done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int px, input int py, input int pc, input bit done);
      exp_t e;
      e.px = px[8:0];
      e.py = py[8:0];
      e.pc = pc[14:0];
      e.done = done;
      sb.push_back(e);
   endtask

   // Expected sweep: 140 x 196 pixels from (89,33), row-major, done on last.
   task automatic push_sweep(input int count);
      int n;
      n = 0;
      for (int cy = 0; cy < 196; cy++) begin
         for (int cx = 0; cx < 140; cx++) begin
            if (n < count) push(89 + cx, 33 + cy, 'h7FFF, (cx == 139 && cy == 195));
            n++;
         end
      end
   endtask

   // Monitor: every plotted pixel must match the head of the scoreboard.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(negedge clock);
         if (plot === 1'b1) begin
            a.px = x; a.py = y; a.pc = colour; a.done = clr_done;
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0h expected no plot", x, y, colour);
            end else begin
               e = sb.pop_front();
               chk("plot_pixel", 64'(a), 64'(e));
            end
         end else begin
            chk("clr_done_without_plot", 64'(clr_done), 64'd0);
         end
      end
   end

   initial begin
      int bad;
      bit exp_o;
      reset = 1'b1; clr_req = 1'b0;
      brush_req = 1'b1; brush_x = 9'd100; brush_y = 9'd50; brush_colour = 15'h001F;
      ovl_req = 1'b0; ovl_x = '0; ovl_y = '0; ovl_colour = '0;
      step();
      step();
      chk("reset_plot", 64'(plot), 64'd0);
      chk("reset_xyc", 64'({x, y, colour}), 64'd0);
      chk("reset_clearing", 64'(clearing), 64'd0);
      chk("reset_clr_done", 64'(clr_done), 64'd0);
      chk("reset_brush_ack", 64'(brush_ack), 64'd0);
      brush_req = 1'b0;
      reset = 1'b0;
      step();

      // Single brush write.
      brush_req = 1'b1; brush_x = 9'd100; brush_y = 9'd50; brush_colour = 15'h001F;
      #1;
      chk("brush_ack", 64'(brush_ack), 64'd1);
      chk("brush_no_ovl_ack", 64'(ovl_ack), 64'd0);
      push(100, 50, 'h001F, 1'b0);
      step();
      brush_req = 1'b0;
      #1;
      chk("brush_ack_drops", 64'(brush_ack), 64'd0);
      step();

      // Clipping.
      brush_req = 1'b1; brush_x = 9'd10; brush_y = 9'd10; brush_colour = 15'h1234;
      #1;
      chk("clip_brush_ack", 64'(brush_ack), 64'd1);
      step();
      brush_req = 1'b0;
      ovl_req = 1'b1; ovl_x = 9'd320; ovl_y = 9'd5; ovl_colour = 15'h0F0F;
      #1;
      chk("clip_ovl_ack", 64'(ovl_ack), 64'd1);
      step();
      ovl_x = 9'd300; ovl_colour = 15'h0ABC;
      #1;
      chk("ovl_edge_ack", 64'(ovl_ack), 64'd1);
      push(300, 5, 'h0ABC, 1'b0);
      step();
      ovl_req = 1'b0;
      step();

      // Aging: both held, 7 brush grants then 1 overlay grant, repeating.
      brush_req = 1'b1; brush_x = 9'd120; brush_y = 9'd60; brush_colour = 15'h0011;
      ovl_req = 1'b1; ovl_x = 9'd10; ovl_y = 9'd20; ovl_colour = 15'h0022;
      for (int i = 0; i < 16; i++) begin
         #1;
         exp_o = (i % 8 == 7);
         chk("aging_ovl_ack", 64'(ovl_ack), 64'(exp_o));
         chk("aging_brush_ack", 64'(brush_ack), 64'(!exp_o));
         if (exp_o) push(10, 20, 'h0022, 1'b0);
         else push(120, 60, 'h0011, 1'b0);
         step();
      end
      brush_req = 1'b0; ovl_req = 1'b0;
      step();

      // Clear with a brush request held throughout.
      clr_req = 1'b1;
      brush_req = 1'b1; brush_x = 9'd200; brush_y = 9'd100; brush_colour = 15'h0005;
      #1;
      chk("clear_wins_no_ack", 64'(brush_ack), 64'd0);
      push_sweep(27440);
      step();
      clr_req = 1'b0;
      #1;
      chk("clearing_next_cycle", 64'(clearing), 64'd1);
      bad = 0;
      for (int i = 0; i < 27440; i++) begin
         if (brush_ack !== 1'b0 || ovl_ack !== 1'b0 || clearing !== 1'b1) bad++;
         step();
      end
      chk("no_ack_during_sweep", 64'(bad), 64'd0);
      chk("brush_ack_after_clear", 64'(brush_ack), 64'd1);
      chk("clearing_low_after", 64'(clearing), 64'd0);
      push(200, 100, 'h0005, 1'b0);
      step();
      brush_req = 1'b0;
      step();
      step();

      // Reset at plot 1000 of a sweep.
      clr_req = 1'b1;
      push_sweep(1000);
      step();
      clr_req = 1'b0;
      repeat (1000) step();
      #5;
      reset = 1'b1;
      #1;
      chk("abort_plot", 64'(plot), 64'd0);
      chk("abort_clearing", 64'(clearing), 64'd0);
      chk("abort_clr_done", 64'(clr_done), 64'd0);
      step();
      chk("abort_sb_drained", 64'(sb.size()), 64'd0);
      reset = 1'b0;
      step();

      // Restarted sweep must begin again at (89,33).
      clr_req = 1'b1;
      push_sweep(27440);
      step();
      clr_req = 1'b0;
      repeat (27443) step();
      chk("final_sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
